// File: rtl/bus_timer_if.sv
// 68000-style asynchronous bus bundle between the CPU side and the timer responder.
interface bus_timer_if;
    logic        cs;
    logic        as_n;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [1:0]  addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        dtack_n;
    logic        irq;

    modport master (
        output cs, as_n, rw, uds_n, lds_n, addr, din,
        input  dout, dtack_n, irq
    );

    modport slave (
        input  cs, as_n, rw, uds_n, lds_n, addr, din,
        output dout, dtack_n, irq
    );
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped 16-bit down-counter timer acting as a wait-stated responder on a 68000 bus.
// Raises a level interrupt when the count expires.
module bus_timer #(
    parameter int WAIT_STATES = 2,
    parameter int PRESCALE    = 25
) (
    input  logic        clk,
    input  logic        reset,
    bus_timer_if.slave  bus
);
    localparam int WCW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
    localparam int PW  = (PRESCALE < 2) ? 1 : $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WCW-1:0]   wait_cnt_r, wait_cnt_s;
    logic             access_s, dtack_n_s, dtack_n_r;
    logic [15:0]      dout_r, rdata_s;
    logic             irq_r;

    logic             en_r, irq_en_r, auto_r, exp_r;
    logic [15:0]      reload_r, count_r;
    logic [PW-1:0]    pre_r;

    logic             wr_s, rd_s, wr_ctrl_s, wr_reload_s, wr_count_s, wr_status_s;
    logic [2:0]       ctrl_wdata_s;
    logic             en_rise_s, tick_s, tick_eff_s, expire_s, clr_exp_s;

    function automatic logic [15:0] merge_lanes(input logic [15:0] old_v, input logic [15:0] new_v,
                                                input logic u_n, input logic l_n);
        logic [15:0] res;
        res[15:8] = u_n ? old_v[15:8] : new_v[15:8];
        res[7:0]  = l_n ? old_v[7:0]  : new_v[7:0];
        return res;
    endfunction

    // Bus FSM next-state; the access strobe fires on the edge that asserts DTACK.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        access_s   = 1'b0;
        dtack_n_s  = dtack_n_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.cs && !bus.as_n) begin
                    if (WAIT_STATES == 0) begin
                        access_s  = 1'b1;
                        dtack_n_s = 1'b0;
                        state_s   = ST_ACK;
                    end else begin
                        wait_cnt_s = WCW'(WAIT_STATES);
                        state_s    = ST_WAIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.as_n) begin
                    state_s = ST_IDLE;
                end else if (wait_cnt_r <= WCW'(1)) begin
                    access_s  = 1'b1;
                    dtack_n_s = 1'b0;
                    state_s   = ST_ACK;
                end else begin
                    wait_cnt_s = wait_cnt_r - WCW'(1);
                end
            end
            ST_ACK: begin
                if (bus.as_n) begin
                    dtack_n_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    dtack_n_s = 1'b0;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                dtack_n_s = 1'b1;
            end
        endcase
    end

    // Bus FSM state, DTACK and read-data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= '0;
            dtack_n_r  <= 1'b1;
            dout_r     <= 16'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            dtack_n_r  <= dtack_n_s;
            if (rd_s) begin
                dout_r <= rdata_s;
            end
        end
    end

    // Access decode and timer event qualification; bus writes to CTRL/COUNT swallow a coincident tick.
    always_comb begin
        wr_s         = access_s && !bus.rw;
        rd_s         = access_s && bus.rw;
        wr_ctrl_s    = wr_s && (bus.addr == 2'd0);
        wr_reload_s  = wr_s && (bus.addr == 2'd1);
        wr_count_s   = wr_s && (bus.addr == 2'd2);
        wr_status_s  = wr_s && (bus.addr == 2'd3);
        ctrl_wdata_s = bus.lds_n ? {auto_r, irq_en_r, en_r} : bus.din[2:0];
        en_rise_s    = wr_ctrl_s && !en_r && ctrl_wdata_s[0];
        clr_exp_s    = wr_status_s && !bus.lds_n && bus.din[0];
        tick_s       = en_r && (pre_r == PRE_MAX);
        tick_eff_s   = tick_s && !wr_ctrl_s && !wr_count_s;
        expire_s     = tick_eff_s && (count_r <= 16'd1);
    end

    // Read mux; the count is sampled before this cycle's tick lands.
    always_comb begin
        rdata_s = 16'd0;
        case (bus.addr)
            2'd0:    rdata_s = {13'd0, auto_r, irq_en_r, en_r};
            2'd1:    rdata_s = reload_r;
            2'd2:    rdata_s = count_r;
            2'd3:    rdata_s = {15'd0, exp_r};
            default: rdata_s = 16'd0;
        endcase
    end

    // Prescaler, control, count, expiry flag and interrupt registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_r    <= '0;
            en_r     <= 1'b0;
            irq_en_r <= 1'b0;
            auto_r   <= 1'b0;
            reload_r <= 16'd0;
            count_r  <= 16'd0;
            exp_r    <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            if (!en_r || en_rise_s || tick_s) begin
                pre_r <= '0;
            end else begin
                pre_r <= pre_r + PW'(1);
            end

            if (wr_ctrl_s) begin
                {auto_r, irq_en_r, en_r} <= ctrl_wdata_s;
            end else if (expire_s && !auto_r) begin
                en_r <= 1'b0;
            end

            if (wr_reload_s) begin
                reload_r <= merge_lanes(reload_r, bus.din, bus.uds_n, bus.lds_n);
            end

            if (wr_count_s) begin
                count_r <= merge_lanes(count_r, bus.din, bus.uds_n, bus.lds_n);
            end else if (expire_s) begin
                count_r <= auto_r ? reload_r : 16'd0;
            end else if (tick_eff_s) begin
                count_r <= count_r - 16'd1;
            end

            // Expiry beats a simultaneous software clear.
            if (expire_s) begin
                exp_r <= 1'b1;
            end else if (clr_exp_s) begin
                exp_r <= 1'b0;
            end

            irq_r <= exp_r & irq_en_r;
        end
    end

    assign bus.dout    = dout_r;
    assign bus.dtack_n = dtack_n_r;
    assign bus.irq     = irq_r;
endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped 16-bit down-counter timer that is a bus responder on the 68000 asynchronous bus.
- It decodes chip-select and address strobe, inserts programmable wait states, and drives DTACKn back to the CPU.
- Reads and writes follow the UDS/LDS byte lanes.
- It sits beside RAM/ROM in the top level and raises an interrupt request line on expiry.

Parameters:
- WAIT_STATES, 2, clk cycles inserted between bus-cycle detection and DTACK assertion (0 allowed).
- PRESCALE, 25, clk cycles per timer tick (25 gives a 1 MHz tick from a 25 MHz clk); minimum 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- cs  input  1  chip select, decoded from the CPU address in the top level.
- as_n  input  1  CPU address strobe, active low.
- rw  input  1  1 = read, 0 = write.
- uds_n  input  1  upper byte strobe, active low.
- lds_n  input  1  lower byte strobe, active low.
- addr  input  2  register select, CPU address bits [2:1].
- din  input  16  write data from the CPU.
- dout  output  16  registered read data.
- dtack_n  output  1  data transfer acknowledge, active low, registered.
- irq  output  1  interrupt request, active high, level.

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (reset).

Register map (by addr):
- 0 CTRL: bit0 EN, bit1 IRQ_EN, bit2 AUTO; bits 15:3 read 0.
- 1 RELOAD: 16-bit reload value.
- 2 COUNT: reads the live count; a write loads the count.
- 3 STATUS: bit0 EXP. Writing 1 to bit0 clears EXP; writing 0 has no effect. Reads have no side effects.

Reset:
- dtack_n=1, dout=0, irq=0.
- CTRL=0, RELOAD=0, COUNT=0, EXP=0, prescaler=0.
- Bus FSM goes to IDLE. Reset takes priority over everything, including a bus cycle in progress.

Bus FSM:
- IDLE: when cs=1 and as_n=0, load wait counter with WAIT_STATES and go to WAIT.
- WAIT: while as_n=0, decrement. At zero, go to ACK and perform the access on that edge:
  - write: update the selected register, byte lanes gated by uds_n (din[15:8]) and lds_n (din[7:0]);
  - read: latch the selected register into dout;
  - dtack_n<=0.
- WAIT with as_n=1: abort to IDLE with no access and no DTACK.
- ACK: hold dtack_n=0 and dout until as_n=1, then dtack_n<=1 and go to IDLE. Exactly one access occurs per as_n assertion.
- Latency: dtack_n falls on the (WAIT_STATES+1)th rising edge after the first edge that samples cs=1 and as_n=0.
- cs is ignored outside IDLE.

Timer:
- While EN=1, the prescaler counts 0..PRESCALE-1 and emits a one-clk tick on wrap.
- While EN=0, the prescaler is held at 0.
- A CTRL write that changes EN from 0 to 1 zeroes the prescaler.
- On tick with COUNT>1: COUNT decrements by 1.
- On tick with COUNT<=1: EXP<=1, and then:
  - AUTO=1: COUNT<=RELOAD, and counting continues;
  - AUTO=0: COUNT<=0 and EN<=0 (one-shot).
- With RELOAD=0 and AUTO=1, the timer expires on every tick.

Interrupt:
- irq = EXP & IRQ_EN, registered, so it lags EXP by one clk.

Simultaneous events:
- A bus write to COUNT or CTRL in the same cycle as a tick: the bus write wins, and that tick's decrement or expiry is discarded.
- A STATUS clear in the same cycle as an expiry: set wins, and EXP stays 1.
- A read of COUNT returns the value before that cycle's tick.

Arithmetic:
- All counters are unsigned. COUNT never wraps below 0.

Test Plan:
1. Reset, then read with WAIT_STATES=2: assert cs=1, as_n=0, rw=1, addr=1 -> dtack_n low on the 3rd edge and dout=0x0000. Raise as_n -> dtack_n=1 on the next edge.
2. Byte-lane write: RELOAD=0x1234, then write din=0xABCD with uds_n=0, lds_n=1 -> RELOAD reads 0xAB34. Repeat with lds_n=0 only -> 0xABCD.
3. One-shot: COUNT=3, CTRL=0b011, PRESCALE=4 -> EXP=1 and irq=1 (one clk later) after 12 clks. CTRL.EN reads 0 and COUNT reads 0. Writing 0x0001 to STATUS -> irq=0.
4. Auto-reload: RELOAD=2, COUNT=2, CTRL=0b101, PRESCALE=1 -> COUNT sequence 2,1,2,1… with EXP set on each reload and irq staying 0.
5. Aborted cycle: raise as_n during WAIT with rw=0 to COUNT -> COUNT unchanged and dtack_n never low. Reset asserted during ACK -> dtack_n=1 on the next edge.
6. Collision: a STATUS-clear write lands on the same edge as an expiry -> EXP remains 1. A COUNT write of 0x0010 coinciding with a tick -> COUNT reads 0x0010.
